// File: rtl/key_event_queue_if.sv
// Bundle of the key-event queue's data signals between the keyboard/video
// side (master) and the queue itself (slave).
interface key_event_queue_if #(
  parameter int DEPTH = 4
);

  logic                     vs;
  logic [7:0]               keycode_raw;
  logic                     flush;
  logic [7:0]               keycode;
  logic [$clog2(DEPTH):0]   pending;
  logic                     overflow;

  modport master (
    output vs,
    output keycode_raw,
    output flush,
    input  keycode,
    input  pending,
    input  overflow
  );

  modport slave (
    input  vs,
    input  keycode_raw,
    input  flush,
    output keycode,
    output pending,
    output overflow
  );

endinterface

// File: rtl/key_event_queue.sv
// Debounces raw HID keycodes, turns game-key presses into events and releases
// them one per VGA frame (on the synchronized vs rising edge) to the tile engine.
module key_event_queue #(
  parameter int DEPTH         = 4,
  parameter int STABLE_CYCLES = 16
) (
  input logic              pixel_clk,
  input logic              Reset_n,
  key_event_queue_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [15:0] LastCount = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] SatCount  = 16'(STABLE_CYCLES);
  localparam logic [AW:0] PtrOne    = (AW + 1)'(1);

  logic [7:0]  r_candidate;
  logic [15:0] r_count;
  logic [7:0]  r_stable;

  logic        r_vsMeta;
  logic        r_vsSync;
  logic        r_vsPrev;
  logic [1:0]  r_syncValid;
  logic        r_armed;

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [7:0]  r_keycode;
  logic        r_overflow;

  logic        w_rawMatch;
  logic        w_accept;
  logic        w_press;
  logic        w_frameTick;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [AW:0] w_pending;

  function automatic logic isGameKey(input logic [7:0] code);
    case (code)
      8'h07, 8'h09, 8'h2C, 8'h0D, 8'h0E: isGameKey = 1'b1;
      default:                           isGameKey = 1'b0;
    endcase
  endfunction

  assign w_rawMatch = (bus.keycode_raw == r_candidate);
  assign w_accept   = w_rawMatch && (r_count == LastCount);
  // A press is a newly accepted game key that differs from the previous stable code.
  assign w_press    = w_accept && isGameKey(r_candidate) && (r_candidate != r_stable);

  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_candidate <= 8'h00;
      r_count     <= 16'h0000;
      r_stable    <= 8'h00;
    end else begin
      if (!w_rawMatch) begin
        r_candidate <= bus.keycode_raw;
        r_count     <= 16'h0000;
      end else if (r_count != SatCount) begin
        r_count <= r_count + 16'd1;
      end
      if (w_accept) begin
        r_stable <= r_candidate;
      end
    end
  end

  // r_syncValid marks when r_vsSync holds a real vs sample rather than its reset
  // zero; ticks stay disarmed until vs has been seen low, so a vs already high
  // at reset release does not count as a frame boundary.
  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vsMeta    <= 1'b0;
      r_vsSync    <= 1'b0;
      r_vsPrev    <= 1'b0;
      r_syncValid <= 2'b00;
      r_armed     <= 1'b0;
    end else begin
      r_vsMeta    <= bus.vs;
      r_vsSync    <= r_vsMeta;
      r_vsPrev    <= r_vsSync;
      r_syncValid <= {r_syncValid[0], 1'b1};
      if (r_syncValid[1] && !r_vsSync) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_frameTick = r_armed && r_vsSync && !r_vsPrev;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = w_frameTick && !w_empty && !bus.flush;
  assign w_push    = w_press && (!w_full || w_pop) && !bus.flush;
  assign w_drop    = w_press && w_full && !w_pop && !bus.flush;
  assign w_pending = r_wptr - r_rptr;

  always_ff @(posedge pixel_clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= r_candidate;
    end
  end

  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_keycode  <= 8'h00;
      r_overflow <= 1'b0;
    end else if (bus.flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_keycode  <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      if (w_frameTick) begin
        r_keycode <= w_pop ? r_mem[r_rptr[AW-1:0]] : 8'h00;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrOne;
      end
      if (w_push) begin
        r_wptr <= r_wptr + PtrOne;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.keycode  = r_keycode;
  assign bus.pending  = w_pending;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: a slow-debounce instance (16 cycles)
// for the main scenarios and a 1-cycle instance for reset/vs timing.
module tb_key_event_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] expQ [$];
  logic       expOverflow;
  logic [7:0] expKey;

  always #5 clk = ~clk;

  key_event_queue_if #(.DEPTH(DEPTH)) bus ();
  key_event_queue_if #(.DEPTH(DEPTH)) fastBus ();

  key_event_queue #(.DEPTH(DEPTH), .STABLE_CYCLES(16)) dut (
    .pixel_clk (clk),
    .Reset_n   (rst_n),
    .bus       (bus)
  );

  key_event_queue #(.DEPTH(DEPTH), .STABLE_CYCLES(1)) fastDut (
    .pixel_clk (clk),
    .Reset_n   (rst_n),
    .bus       (fastBus)
  );

  function automatic bit isGame(input logic [7:0] c);
    return (c == 8'h07) || (c == 8'h09) || (c == 8'h2C) || (c == 8'h0D) || (c == 8'h0E);
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold a key long enough to be accepted, release it, and record the expected event.
  task automatic applyStimulus(input logic [7:0] code);
    bus.keycode_raw = code;
    waitCycles(20);
    bus.keycode_raw = 8'h00;
    waitCycles(20);
    if (isGame(code)) begin
      if (expQ.size() < DEPTH) expQ.push_back(code);
      else expOverflow = 1'b1;
    end
  endtask

  task automatic runFrame();
    bus.vs = 1'b1;
    waitCycles(4);
    bus.vs = 1'b0;
    waitCycles(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.vs = 1'b0; bus.keycode_raw = 8'h00; bus.flush = 1'b0;
    fastBus.vs = 1'b0; fastBus.keycode_raw = 8'h00; fastBus.flush = 1'b0;
    expOverflow = 1'b0;
    #12;
    checks++; if (bus.keycode !== 8'h00) begin errors++; $display("[TB] FAIL reset_keycode: got %0h expected 0", bus.keycode); end
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("[TB] FAIL reset_pending: got %0d expected 0", bus.pending); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0b expected 0", bus.overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(30);
  endtask

  task automatic test_single_press();
    bus.keycode_raw = 8'h09;
    waitCycles(60);
    expQ.push_back(8'h09);
    checks++; if (bus.pending !== 3'(expQ.size())) begin errors++; $display("[TB] FAIL hold_one_event: got %0d expected %0d", bus.pending, expQ.size()); end
    bus.keycode_raw = 8'h00;
    waitCycles(20);
    runFrame();
    expKey = expQ.pop_front();
    checks++; if (bus.keycode !== expKey) begin errors++; $display("[TB] FAIL single_keycode: got %0h expected %0h", bus.keycode, expKey); end
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("[TB] FAIL single_pending: got %0d expected 0", bus.pending); end
    waitCycles(20);
    checks++; if (bus.keycode !== expKey) begin errors++; $display("[TB] FAIL keycode_held: got %0h expected %0h", bus.keycode, expKey); end
    runFrame();
    checks++; if (bus.keycode !== 8'h00) begin errors++; $display("[TB] FAIL next_frame_zero: got %0h expected 0", bus.keycode); end
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 40; i++) begin
      bus.keycode_raw = (i % 2 == 0) ? 8'h07 : 8'h00;
      waitCycles(5);
    end
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("[TB] FAIL bounce_pending: got %0d expected 0", bus.pending); end
    bus.keycode_raw = 8'h04;
    waitCycles(100);
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("[TB] FAIL nongame_pending: got %0d expected 0", bus.pending); end
    bus.keycode_raw = 8'h00;
    waitCycles(20);
  endtask

  task automatic test_key_change();
    bus.keycode_raw = 8'h07; waitCycles(20);
    bus.keycode_raw = 8'h0E; waitCycles(20);
    bus.keycode_raw = 8'h04; waitCycles(20);
    bus.keycode_raw = 8'h07; waitCycles(20);
    bus.keycode_raw = 8'h00; waitCycles(20);
    expQ.push_back(8'h07); expQ.push_back(8'h0E); expQ.push_back(8'h07);
    checks++; if (bus.pending !== 3'(expQ.size())) begin errors++; $display("[TB] FAIL change_pending: got %0d expected %0d", bus.pending, expQ.size()); end
    for (int i = 0; i < 3; i++) begin
      runFrame();
      expKey = (expQ.size() > 0) ? expQ.pop_front() : 8'h00;
      checks++; if (bus.keycode !== expKey) begin errors++; $display("[TB] FAIL change_order: got %0h expected %0h", bus.keycode, expKey); end
    end
  endtask

  task automatic test_overflow();
    applyStimulus(8'h07); applyStimulus(8'h09); applyStimulus(8'h2C);
    applyStimulus(8'h0D); applyStimulus(8'h0E);
    checks++; if (bus.pending !== 3'(expQ.size())) begin errors++; $display("[TB] FAIL full_pending: got %0d expected %0d", bus.pending, expQ.size()); end
    checks++; if (bus.overflow !== expOverflow) begin errors++; $display("[TB] FAIL overflow_set: got %0b expected %0b", bus.overflow, expOverflow); end
    for (int i = 0; i < 5; i++) begin
      runFrame();
      expKey = (expQ.size() > 0) ? expQ.pop_front() : 8'h00;
      checks++; if (bus.keycode !== expKey) begin errors++; $display("[TB] FAIL drain_keycode: got %0h expected %0h", bus.keycode, expKey); end
      checks++; if (bus.pending !== 3'(expQ.size())) begin errors++; $display("[TB] FAIL drain_pending: got %0d expected %0d", bus.pending, expQ.size()); end
    end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_sticky: got %0b expected 1", bus.overflow); end
    bus.flush = 1'b1;
    waitCycles(1);
    bus.flush = 1'b0;
    expOverflow = 1'b0;
    checks++; if (bus.overflow !== expOverflow) begin errors++; $display("[TB] FAIL flush_overflow: got %0b expected 0", bus.overflow); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(8'h07); applyStimulus(8'h09); applyStimulus(8'h2C); applyStimulus(8'h0D);
    checks++; if (bus.pending !== 3'd4) begin errors++; $display("[TB] FAIL prefill_pending: got %0d expected 4", bus.pending); end
    // Raw key seen at edge 1 is accepted at edge 17; vs seen at edge 15 ticks at edge 17.
    bus.keycode_raw = 8'h0E;
    waitCycles(14);
    bus.vs = 1'b1;
    waitCycles(6);
    expKey = expQ.pop_front();
    expQ.push_back(8'h0E);
    checks++; if (bus.pending !== 3'd4) begin errors++; $display("[TB] FAIL simul_pending: got %0d expected 4", bus.pending); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL simul_overflow: got %0b expected 0", bus.overflow); end
    checks++; if (bus.keycode !== expKey) begin errors++; $display("[TB] FAIL simul_keycode: got %0h expected %0h", bus.keycode, expKey); end
    bus.keycode_raw = 8'h00;
    bus.vs = 1'b0;
    waitCycles(20);
    for (int i = 0; i < 5; i++) begin
      runFrame();
      expKey = (expQ.size() > 0) ? expQ.pop_front() : 8'h00;
      checks++; if (bus.keycode !== expKey) begin errors++; $display("[TB] FAIL simul_order: got %0h expected %0h", bus.keycode, expKey); end
    end
  endtask

  task automatic test_flush_coincident();
    applyStimulus(8'h07); applyStimulus(8'h09); applyStimulus(8'h2C);
    runFrame();
    expKey = expQ.pop_front();
    checks++; if (bus.keycode !== expKey) begin errors++; $display("[TB] FAIL preflush_keycode: got %0h expected %0h", bus.keycode, expKey); end
    bus.keycode_raw = 8'h0D;
    waitCycles(14);
    bus.vs = 1'b1;
    waitCycles(2);
    bus.flush = 1'b1;
    waitCycles(1);
    bus.flush = 1'b0;
    expQ.delete();
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("[TB] FAIL flush_pending: got %0d expected 0", bus.pending); end
    checks++; if (bus.keycode !== 8'h00) begin errors++; $display("[TB] FAIL flush_keycode: got %0h expected 0", bus.keycode); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL flush_overflow2: got %0b expected 0", bus.overflow); end
    waitCycles(10);
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("[TB] FAIL flush_held_key: got %0d expected 0", bus.pending); end
    bus.keycode_raw = 8'h00;
    bus.vs = 1'b0;
    waitCycles(20);
  endtask

  task automatic test_flush_held();
    bus.flush = 1'b1;
    bus.keycode_raw = 8'h09;
    waitCycles(25);
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("[TB] FAIL flush_hold_pending: got %0d expected 0", bus.pending); end
    bus.flush = 1'b0;
    waitCycles(3);
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("[TB] FAIL after_flush_pending: got %0d expected 0", bus.pending); end
    bus.keycode_raw = 8'h00;
    waitCycles(20);
    applyStimulus(8'h2C);
    checks++; if (bus.pending !== 3'(expQ.size())) begin errors++; $display("[TB] FAIL resume_pending: got %0d expected %0d", bus.pending, expQ.size()); end
    runFrame();
    expKey = (expQ.size() > 0) ? expQ.pop_front() : 8'h00;
    checks++; if (bus.keycode !== expKey) begin errors++; $display("[TB] FAIL resume_keycode: got %0h expected %0h", bus.keycode, expKey); end
  endtask

  task automatic test_reset_midframe();
    applyStimulus(8'h0E); applyStimulus(8'h07); applyStimulus(8'h09); applyStimulus(8'h2C);
    runFrame();
    expKey = expQ.pop_front();
    checks++; if (bus.keycode !== expKey) begin errors++; $display("[TB] FAIL prereset_keycode: got %0h expected %0h", bus.keycode, expKey); end
    checks++; if (bus.pending !== 3'(expQ.size())) begin errors++; $display("[TB] FAIL prereset_pending: got %0d expected %0d", bus.pending, expQ.size()); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.vs = 1'b1; bus.keycode_raw = 8'h07;
    fastBus.vs = 1'b1; fastBus.keycode_raw = 8'h07;
    expQ.delete();
    #1;
    checks++; if (bus.keycode !== 8'h00) begin errors++; $display("[TB] FAIL async_keycode: got %0h expected 0", bus.keycode); end
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("[TB] FAIL async_pending: got %0d expected 0", bus.pending); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL async_overflow: got %0b expected 0", bus.overflow); end
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(1);
    checks++; if (fastBus.pending !== 3'd0) begin errors++; $display("[TB] FAIL fast_first_cycle: got %0d expected 0", fastBus.pending); end
    waitCycles(1);
    checks++; if (fastBus.pending !== 3'd1) begin errors++; $display("[TB] FAIL fast_accept: got %0d expected 1", fastBus.pending); end
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("[TB] FAIL slow_not_yet: got %0d expected 0", bus.pending); end
    waitCycles(3);
    checks++; if (fastBus.keycode !== 8'h00) begin errors++; $display("[TB] FAIL no_tick_keycode: got %0h expected 0", fastBus.keycode); end
    checks++; if (fastBus.pending !== 3'd1) begin errors++; $display("[TB] FAIL no_tick_pending: got %0d expected 1", fastBus.pending); end
    waitCycles(27);
    expQ.push_back(8'h07);
    checks++; if (bus.pending !== 3'd1) begin errors++; $display("[TB] FAIL reaccept_pending: got %0d expected 1", bus.pending); end
    checks++; if (bus.keycode !== 8'h00) begin errors++; $display("[TB] FAIL vs_high_keycode: got %0h expected 0", bus.keycode); end
    bus.vs = 1'b0; fastBus.vs = 1'b0;
    waitCycles(4);
    bus.vs = 1'b1; fastBus.vs = 1'b1;
    waitCycles(4);
    expKey = expQ.pop_front();
    checks++; if (bus.keycode !== expKey) begin errors++; $display("[TB] FAIL rearm_keycode: got %0h expected %0h", bus.keycode, expKey); end
    checks++; if (fastBus.keycode !== 8'h07) begin errors++; $display("[TB] FAIL fast_rearm_keycode: got %0h expected 07", fastBus.keycode); end
    bus.vs = 1'b0; fastBus.vs = 1'b0;
    bus.keycode_raw = 8'h00; fastBus.keycode_raw = 8'h00;
    waitCycles(10);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_debounce();
    test_key_change();
    test_overflow();
    test_back_to_back();
    test_flush_coincident();
    test_flush_held();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries; power of two, minimum 2.
REQ-002 Parameter: STABLE_CYCLES, 16, consecutive pixel_clk cycles a raw keycode must hold before it is accepted; range 1..65535.
REQ-003 Port: pixel_clk  input  1  sole clock; all state on its rising edge.
REQ-004 Port: Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: vs  input  1  VGA vertical sync level; asynchronous to the block, rising edge marks the frame boundary.
REQ-006 Port: keycode_raw  input  8  USB HID keycode from the keyboard interface, 0 = no key.
REQ-007 Port: flush  input  1  synchronous clear of queue, output and overflow (game restart).
REQ-008 Port: keycode  output  8  registered, frame-aligned key event for the tile engine; 0 = no event this frame.
REQ-009 Port: pending  output  clog2(DEPTH)+1  number of queued events, 0..DEPTH.
REQ-010 Port: overflow  output  1  sticky; an event was dropped because the queue was full.

Function
REQ-011 Game keys are exactly 8'h07 (D), 8'h09 (F), 8'h2C (SPACE), 8'h0D (J), 8'h0E (K); every other nonzero code is a non-game key.
REQ-012 Debounce: candidate register plus 16-bit counter; keycode_raw differing from candidate loads candidate and clears counter; equal increments counter, saturating at STABLE_CYCLES.
REQ-013 Stable register loads candidate on the cycle the counter reaches STABLE_CYCLES-1 with keycode_raw still equal to candidate; with STABLE_CYCLES=1 a raw value is accepted on the cycle after it first appears.
REQ-014 Press event: single-cycle pulse when stable changes to a game key different from its previous value (0->key or key->other key); holding a key produces exactly one event; releasing (->0) or changing to a non-game key produces none.
REQ-015 vs passes through a 2-flop synchronizer; frame_tick is the one-cycle pulse on synchronized-vs rising edge (third flop for edge detect).
REQ-016 On frame_tick: queue nonempty -> head popped into keycode; queue empty -> keycode set to 0.
REQ-017 keycode changes only on frame_tick or flush and is otherwise held for the whole frame.
REQ-018 Press event with queue not full -> write at tail, pending +1 next cycle.
REQ-019 Press event with queue full and no concurrent pop -> event dropped, overflow set, pending stays DEPTH.
REQ-020 Press event and frame_tick same cycle: pop head and push new event together; pending unchanged; accepted even when full; when empty the new event goes to the queue, not to keycode (keycode becomes 0).
REQ-021 Read/write pointers are clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty derived from pointer MSB comparison; pending = wptr - rptr.
REQ-022 FIFO order strict: events leave in press order, one per frame.
REQ-023 flush: next cycle pending=0, keycode=0, overflow=0; flush wins over a concurrent push or pop (both discarded); debounce and vs-sync state unaffected.
REQ-024 flush held several cycles keeps the block cleared; events resume on the first cycle flush is low.

Reset
REQ-025 Reset_n low asynchronously forces keycode=0, pending=0, overflow=0, pointers=0, candidate=0, stable=0, debounce counter=0, sync/edge flops=0.
REQ-026 Reset_n release takes effect synchronously; a vs already high at release yields no frame_tick until vs goes low then high.
REQ-027 Reset mid-debounce or mid-frame discards all partial state; no event is generated from a key held through reset until it is accepted again per REQ-012..014.

Verification
REQ-028 STABLE_CYCLES=16; keycode_raw=8'h09 for 16 cycles, then vs pulse -> pending 1 then 0; keycode=8'h09 for exactly one frame, then 0 on next frame_tick.
REQ-029 keycode_raw toggles 8'h07/8'h00 every 5 cycles for 200 cycles -> no event, pending stays 0; keycode_raw=8'h04 held 100 cycles -> no event.
REQ-030 DEPTH=4, five presses D,F,SPACE,J,K with no vs -> pending 4, overflow=1; five frames -> keycode 07,09,2C,0D,00.
REQ-031 Queue full (4) and press accepted on the same cycle as frame_tick -> pending stays 4, overflow stays 0, pop order preserves new event last.
REQ-032 Queue holding 2 events, flush coincident with press and frame_tick -> next cycle pending=0, keycode=0, overflow=0.
REQ-033 Reset_n asserted while pending=3 and keycode=8'h0E, between clock edges -> all outputs 0 immediately; after release, 2 cycles of vs high produce no frame_tick.
